icb_mem_slave: RTL and testbench
================================

# icb_mem_slave

ICB responder with a word-organised register-array memory. It acts as the target end of the ICB bus that the DMA engine drives as a master: it accepts read/write commands, applies byte write masks, flags out-of-range accesses and returns in-order responses through a small buffer. It serves as the DMA source/destination memory in system integration and as the DMA bench's bus model, with optional wait states and response back-pressure.

## Interface
- BASE_ADDR, 32'h2000_0000, byte base address of the window; must be aligned to 4·2^AW.
- AW, 10, word-index width; the window spans 2^AW 32-bit words (4 KiB by default).
- DEPTH, 2, response buffer entries, 1..4; this is also the maximum number of outstanding commands.
- WAIT_STATES, 0, cycles cmd_ready is withheld per command, 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- icb_cmd_valid  in  1  master command request.
- icb_cmd_ready  out  1  command accepted when valid & ready.
- icb_cmd_addr  in  32  byte address; bits [1:0] are ignored.
- icb_cmd_read  in  1  1 = read, 0 = write.
- icb_cmd_wdata  in  32  write data.
- icb_cmd_wmask  in  4  byte enables; bit i enables wdata[8i+7:8i].
- icb_rsp_valid  out  1  response available.
- icb_rsp_ready  in  1  master accepts the response.
- icb_rsp_rdata  out  32  read data; 0 for writes and errors.
- icb_rsp_err  out  1  access was outside the window.

## Operation
- Address decode:
  - in_range = (addr − BASE_ADDR) < 4·2^AW, computed with unsigned 32-bit subtraction, so addresses below the base wrap and decode as out of range.
  - Word index = addr[AW+1:2].
- Accepted write, in range: each byte lane with wmask bit = 1 is updated at the acceptance edge. wmask = 4'b0000 is a legal no-op and does not set err. The response carries rdata = 0, err = 0.
- Accepted read, in range: the word is read combinationally in the acceptance cycle and captured into the response buffer.
- Out-of-range command: memory is not modified, rdata = 0, err = 1.
- Response buffer: DEPTH-entry FIFO of {rdata, err}. Responses return strictly in command order.
- Outstanding counter cnt (0..DEPTH):
  - +1 on command accept; −1 on response handshake; both in the same cycle leaves it unchanged.
  - cnt never exceeds DEPTH.
- Wait counter wcnt (0..WAIT_STATES):
  - Increments while icb_cmd_valid = 1 and wcnt < WAIT_STATES.
  - Clears to 0 on accept.
  - Holds its value if valid drops before the command is accepted.
- icb_cmd_ready = (wcnt == WAIT_STATES) & (cnt < DEPTH) & reset released.
  - There is no combinational path from icb_rsp_ready to icb_cmd_ready.
- Memory contents are not reset; a read before any write returns X in simulation.

## Timing
- Reset values, asserted asynchronously: icb_cmd_ready 0, icb_rsp_valid 0, icb_rsp_rdata 0, icb_rsp_err 0, cnt 0, wcnt 0, FIFO pointers 0.
  - The first accept is possible in the first cycle after rst_n deasserts when WAIT_STATES = 0.
- Latency: a command accepted in cycle N makes icb_rsp_valid = 1 in cycle N+1 if the buffer was empty; otherwise the response follows the earlier entries.
- icb_rsp_valid, rdata and err are stable while valid & ~ready; the head advances only on handshake.
- Throughput, with icb_rsp_ready held at 1 and WAIT_STATES = 0:
  - DEPTH ≥ 2: one command per cycle.
  - DEPTH = 1: one command every 2 cycles.
- Back-pressure: with icb_rsp_ready = 0, exactly DEPTH commands are accepted, then icb_cmd_ready = 0 until a response retires. cmd_ready rises in the cycle after that retirement.
- Read-after-write to the same word in back-to-back cycles returns the newly written data.
- Asserting rst_n mid-transfer drops all pending responses. The master must also reset; there is no error response for dropped commands.

## Test plan
- Full write then read: write 32'hDEAD_BEEF with wmask 4'hF to BASE+0x10, then read BASE+0x10 → read response rdata = 32'hDEAD_BEEF, err = 0, icb_rsp_valid one cycle after accept.
- Byte mask: write 32'h1122_3344 with mask 4'hF, then write 32'hAAAA_AAAA with mask 4'b0101, then read the word → 32'h11AA_33AA. A write with mask 4'b0000 leaves the word unchanged.
- Out of range: write to BASE+0x1000 (AW = 10), then read BASE−4 → both responses have err = 1, rdata = 0; a later read of BASE+0x0 is unaffected.
- Back-pressure: hold rsp_ready = 0 and issue 4 reads → exactly 2 accepted and cmd_ready = 0; pulse rsp_ready for 1 cycle → one response retires and cmd_ready returns the next cycle; all responses arrive in order.
- Streaming: with WAIT_STATES = 0 and rsp_ready = 1, 16 back-to-back writes to consecutive words then 16 reads → 1 command per cycle and all data matches. Rerun with WAIT_STATES = 3 → each command is accepted exactly 4 cycles after valid rises.
- Reset mid-operation: with 2 responses pending, pulse rst_n low → rsp_valid = 0 and cmd_ready = 0 immediately; after release cnt = 0 and new commands are accepted.

Source files
------------

// File: rtl/icb_mem_slave_if.sv
// ---------------------------------------------------------------------------
// icb_mem_slave_if
//   ICB command/response bundle between a bus master (e.g. the DMA engine)
//   and a memory responder.
//
//   Command channel : icb_cmd_valid/ready, icb_cmd_addr, icb_cmd_read,
//                     icb_cmd_wdata, icb_cmd_wmask   (master -> slave)
//   Response channel: icb_rsp_valid/ready, icb_rsp_rdata, icb_rsp_err
//                     (slave -> master, ready from master)
// ---------------------------------------------------------------------------
interface icb_mem_slave_if;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
               icb_cmd_wmask, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
               icb_cmd_wmask, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );
endinterface

// File: rtl/icb_mem_slave.sv
// ---------------------------------------------------------------------------
// icb_mem_slave
//   ICB target with a 2^AW x 32-bit register-array memory mapped at
//   BASE_ADDR. Writes honour byte masks, accesses outside the window return
//   err = 1 without touching memory, and responses are returned in command
//   order through a DEPTH-entry buffer. Optional wait states hold off
//   icb_cmd_ready for WAIT_STATES cycles per command.
//
//   Ports:
//     clk    - clock, all state changes on the rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - icb_mem_slave_if.slave (command in, response out)
//
//   Parameters:
//     BASE_ADDR   - byte base of the window, aligned to 4*2^AW
//     AW          - word-index width
//     DEPTH       - response buffer entries / max outstanding (1..4)
//     WAIT_STATES - cycles icb_cmd_ready is withheld per command (0..15)
// ---------------------------------------------------------------------------
module icb_mem_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int unsigned AW          = 10,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    icb_mem_slave_if.slave   bus
);

    localparam int unsigned WORDS     = 1 << AW;
    localparam logic [31:0] WIN_BYTES = 32'd4 << AW;
    localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW        = $clog2(DEPTH + 1);
    localparam int unsigned WW        = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic [31:0]   mem [WORDS];
    rsp_t          fifo [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic [WW-1:0] wcnt;

    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] widx;
    logic          cmd_hs;
    logic          rsp_hs;
    rsp_t          new_rsp;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Unsigned subtraction: addresses below the base wrap to a huge offset
    // and therefore decode as out of range.
    assign offset   = bus.icb_cmd_addr - BASE_ADDR;
    assign in_range = (offset < WIN_BYTES);
    assign widx     = bus.icb_cmd_addr[AW+1:2];

    // cmd_ready looks only at registered state (plus reset), so there is no
    // path from icb_rsp_ready; a slot freed this cycle is usable next cycle.
    assign bus.icb_cmd_ready = (wcnt == WW'(WAIT_STATES)) && (cnt < CW'(DEPTH)) && rst_n;
    assign bus.icb_rsp_valid = (cnt != '0);

    assign cmd_hs = bus.icb_cmd_valid & bus.icb_cmd_ready;
    assign rsp_hs = bus.icb_rsp_valid & bus.icb_rsp_ready;

    // Response captured at acceptance; the read sees memory before any
    // write at this edge, and a write on the previous edge is already visible.
    always_comb begin
        // NOTE: defaulting every field first keeps this block free of latches.
        new_rsp     = '0;
        new_rsp.err = ~in_range;
        if (bus.icb_cmd_read && in_range) begin
            new_rsp.rdata = mem[widx];
        end
    end

    // Rdata/err are forced to zero when no response is held so the outputs
    // come out of reset at 0 without resetting the buffer storage.
    assign bus.icb_rsp_rdata = bus.icb_rsp_valid ? fifo[rptr].rdata : '0;
    assign bus.icb_rsp_err   = bus.icb_rsp_valid ? fifo[rptr].err   : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            wcnt <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            unique case ({cmd_hs, rsp_hs})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            if (cmd_hs) begin
                wcnt <= '0;
                wptr <= ptr_inc(wptr);
            end else if (bus.icb_cmd_valid && (wcnt < WW'(WAIT_STATES))) begin
                wcnt <= wcnt + 1'b1;
            end

            if (rsp_hs) begin
                rptr <= ptr_inc(rptr);
            end
        end
    end

    // NOTE: memory and buffer storage carry no reset; they are plain register
    // arrays whose contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            fifo[wptr] <= new_rsp;
        end
        if (cmd_hs && !bus.icb_cmd_read && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.icb_cmd_wmask[i]) begin
                    mem[widx][8*i +: 8] <= bus.icb_cmd_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_icb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_icb_mem_slave
//   Two responders: u_dut0 (WAIT_STATES = 0) and u_dut1 (WAIT_STATES = 3),
//   both DEPTH = 2 with the default window. A transaction-level model
//   (word map + response queue per instance) is compared against the
//   outputs on every falling edge; directed sequences add literal checks.
// ---------------------------------------------------------------------------
module tb_icb_mem_slave;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam logic [31:0] WIN   = 32'h0000_1000;
    localparam int          DEPTH = 2;
    localparam int          WORDS = 1024;

    logic clk;
    logic rst_n;

    icb_mem_slave_if b0 ();
    icb_mem_slave_if b1 ();

    icb_mem_slave #(.BASE_ADDR(BASE), .AW(10), .DEPTH(DEPTH), .WAIT_STATES(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    icb_mem_slave #(.BASE_ADDR(BASE), .AW(10), .DEPTH(DEPTH), .WAIT_STATES(3))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Model: expected responses ({rdata, err}) per instance and a word map
    // ------------------------------------------------------------------
    logic [32:0] q0[$], q1[$];
    logic [32:0] log0[$], log1[$];
    logic [31:0] mm[int];
    int          waited_m[2];
    int          ws_of[2] = '{0, 3};

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [32:0] q_front(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic model_step(input int k, input logic rst, input logic cv, input logic cr,
                              input logic [31:0] a, input logic rd, input logic [31:0] wd,
                              input logic [3:0] wm, input logic rv, input logic rr,
                              input logic [31:0] rdata, input logic err);
        logic [31:0] off;
        logic [31:0] word;
        logic [32:0] rsp;
        int          key;
        if (!rst) begin
            if (k == 0) q0.delete(); else q1.delete();
            waited_m[k] = 0;
            check($sformatf("rst_cmd_ready%0d", k), 64'(cr), 64'd0);
            check($sformatf("rst_rsp_valid%0d", k), 64'(rv), 64'd0);
            check($sformatf("rst_rsp%0d", k), 64'({rdata, err}), 64'd0);
            return;
        end
        check($sformatf("cmd_ready%0d", k), 64'(cr),
              64'((q_size(k) < DEPTH) && (waited_m[k] >= ws_of[k])));
        check($sformatf("rsp_valid%0d", k), 64'(rv), 64'(q_size(k) != 0));
        if (q_size(k) != 0)
            check($sformatf("rsp_data%0d", k), 64'({rdata, err}), 64'(q_front(k)));
        // Events at the coming rising edge: retire first, then accept.
        if (rv && rr && q_size(k) != 0) begin
            if (k == 0) begin log0.push_back({rdata, err}); void'(q0.pop_front()); end
            else        begin log1.push_back({rdata, err}); void'(q1.pop_front()); end
        end
        if (cv && cr) begin
            off = a - BASE;
            if (off < WIN) begin
                key  = k * WORDS + int'(off >> 2);
                word = mm.exists(key) ? mm[key] : 32'hx;
                if (rd) begin
                    rsp = {word, 1'b0};
                end else begin
                    for (int i = 0; i < 4; i++)
                        if (wm[i]) word[8*i +: 8] = wd[8*i +: 8];
                    mm[key] = word;
                    rsp = 33'd0;
                end
            end else begin
                rsp = {32'd0, 1'b1};
            end
            if (k == 0) q0.push_back(rsp); else q1.push_back(rsp);
            waited_m[k] = 0;
        end else if (cv) begin
            waited_m[k]++;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, rst_n, b0.icb_cmd_valid, b0.icb_cmd_ready, b0.icb_cmd_addr,
                   b0.icb_cmd_read, b0.icb_cmd_wdata, b0.icb_cmd_wmask,
                   b0.icb_rsp_valid, b0.icb_rsp_ready, b0.icb_rsp_rdata, b0.icb_rsp_err);
        model_step(1, rst_n, b1.icb_cmd_valid, b1.icb_cmd_ready, b1.icb_cmd_addr,
                   b1.icb_cmd_read, b1.icb_cmd_wdata, b1.icb_cmd_wmask,
                   b1.icb_rsp_valid, b1.icb_rsp_ready, b1.icb_rsp_rdata, b1.icb_rsp_err);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge + 1)
    // ------------------------------------------------------------------
    task automatic set_cmd(input int k, input logic v, input logic [31:0] a, input logic rd,
                           input logic [31:0] wd, input logic [3:0] wm);
        if (k == 0) begin
            b0.icb_cmd_valid = v; b0.icb_cmd_addr = a; b0.icb_cmd_read = rd;
            b0.icb_cmd_wdata = wd; b0.icb_cmd_wmask = wm;
        end else begin
            b1.icb_cmd_valid = v; b1.icb_cmd_addr = a; b1.icb_cmd_read = rd;
            b1.icb_cmd_wdata = wd; b1.icb_cmd_wmask = wm;
        end
    endtask

    task automatic idle(input int k);
        if (k == 0) b0.icb_cmd_valid = 1'b0; else b1.icb_cmd_valid = 1'b0;
    endtask

    task automatic set_rr(input int k, input logic v);
        if (k == 0) b0.icb_rsp_ready = v; else b1.icb_rsp_ready = v;
    endtask

    function automatic logic get_ready(input int k);
        return (k == 0) ? b0.icb_cmd_ready : b1.icb_cmd_ready;
    endfunction

    function automatic logic [33:0] peek_rsp(input int k);
        return (k == 0) ? {b0.icb_rsp_valid, b0.icb_rsp_rdata, b0.icb_rsp_err}
                        : {b1.icb_rsp_valid, b1.icb_rsp_rdata, b1.icb_rsp_err};
    endfunction

    // Presents a command (valid left high) and returns once it is accepted;
    // 'waited' is the number of cycles valid was high without ready.
    task automatic issue(input int k, input logic [31:0] a, input logic rd,
                         input logic [31:0] wd, input logic [3:0] wm, output int waited);
        set_cmd(k, 1'b1, a, rd, wd, wm);
        waited = 0;
        forever begin
            @(negedge clk);
            if (get_ready(k)) break;
            waited++;
            if (waited > 100) begin fail_now("issue_timeout"); break; end
        end
        @(posedge clk); #1;
    endtask

    // Single command with response ready high: the response must be valid
    // in the cycle after acceptance with the given data/err.
    task automatic op_expect(input int k, input string name, input logic [31:0] a,
                             input logic rd, input logic [31:0] wd, input logic [3:0] wm,
                             input logic [31:0] exp_data, input logic exp_err,
                             input int exp_wait);
        int w;
        issue(k, a, rd, wd, wm, w);
        idle(k);
        check({name, "_wait"}, 64'(w), 64'(exp_wait));
        @(negedge clk);
        check({name, "_rsp"}, 64'(peek_rsp(k)), 64'({1'b1, exp_data, exp_err}));
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input int k);
        int n = 0;
        while (q_size(k) != 0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin fail_now("drain_timeout"); break; end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int w;
        int tw;
        rst_n = 1'b0;
        set_cmd(0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        set_cmd(1, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        set_rr(0, 1'b1);
        set_rr(1, 1'b1);

        // Reset and first-cycle readiness
        @(negedge clk);
        check("reset_ready", 64'(b0.icb_cmd_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_cycle_ready", 64'(b0.icb_cmd_ready), 64'd1);
        @(posedge clk); #1;

        // Full write then read, back to back
        issue(0, BASE + 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF, w);
        op_expect(0, "rd_deadbeef", BASE + 32'h10, 1'b1, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);

        // Byte masks
        op_expect(0, "wr_full", BASE + 32'h20, 1'b0, 32'h1122_3344, 4'hF, 32'd0, 1'b0, 0);
        op_expect(0, "wr_mask5", BASE + 32'h20, 1'b0, 32'hAAAA_AAAA, 4'b0101, 32'd0, 1'b0, 0);
        op_expect(0, "rd_masked", BASE + 32'h20, 1'b1, 32'd0, 4'h0, 32'h11AA_33AA, 1'b0, 0);
        op_expect(0, "wr_mask0", BASE + 32'h20, 1'b0, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0, 0);
        op_expect(0, "rd_mask0", BASE + 32'h20, 1'b1, 32'd0, 4'h0, 32'h11AA_33AA, 1'b0, 0);

        // Out of range: one past the top (aliases word 0 in its low bits) and below base
        op_expect(0, "wr_base0", BASE, 1'b0, 32'h1234_5678, 4'hF, 32'd0, 1'b0, 0);
        op_expect(0, "wr_oor_top", BASE + 32'h1000, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, 0);
        op_expect(0, "rd_oor_low", BASE - 32'h4, 1'b1, 32'd0, 4'h0, 32'd0, 1'b1, 0);
        op_expect(0, "rd_base0", BASE, 1'b1, 32'd0, 4'h0, 32'h1234_5678, 1'b0, 0);
        op_expect(0, "rd_last", BASE + 32'hFFC, 1'b1, 32'd0, 4'h0, 32'hx, 1'b0, 0);

        // Back-pressure with DEPTH = 2
        log0.delete();
        set_rr(0, 1'b0);
        issue(0, BASE + 32'h10, 1'b1, 32'd0, 4'h0, w);
        check("bp_acc1_wait", 64'(w), 64'd0);
        issue(0, BASE + 32'h20, 1'b1, 32'd0, 4'h0, w);
        check("bp_acc2_wait", 64'(w), 64'd0);
        set_cmd(0, 1'b1, BASE, 1'b1, 32'd0, 4'h0);
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", 64'(b0.icb_cmd_ready), 64'd0);
        end
        @(posedge clk); #1 set_rr(0, 1'b1);
        @(negedge clk);
        check("bp_no_comb_path", 64'(b0.icb_cmd_ready), 64'd0);
        @(posedge clk); #1 set_rr(0, 1'b0);
        @(negedge clk);
        check("bp_ready_return", 64'(b0.icb_cmd_ready), 64'd1);
        @(posedge clk); #1;
        set_rr(0, 1'b1);
        issue(0, BASE + 32'h10, 1'b1, 32'd0, 4'h0, w);
        idle(0);
        wait_drain(0);
        check("bp_count", 64'(log0.size()), 64'd4);
        if (log0.size() == 4) begin
            check("bp_order0", 64'(log0[0]), 64'({32'hDEAD_BEEF, 1'b0}));
            check("bp_order1", 64'(log0[1]), 64'({32'h11AA_33AA, 1'b0}));
            check("bp_order2", 64'(log0[2]), 64'({32'h1234_5678, 1'b0}));
            check("bp_order3", 64'(log0[3]), 64'({32'hDEAD_BEEF, 1'b0}));
        end

        // Streaming, no wait states: one command per cycle
        tw = 0;
        for (int i = 0; i < 16; i++) begin
            issue(0, BASE + 32'h100 + 32'(4 * i), 1'b0, 32'hA5A5_0000 + 32'(i), 4'hF, w);
            tw += w;
        end
        check("stream_wr_stalls", 64'(tw), 64'd0);
        log0.delete();
        tw = 0;
        for (int i = 0; i < 16; i++) begin
            issue(0, BASE + 32'h100 + 32'(4 * i), 1'b1, 32'd0, 4'h0, w);
            tw += w;
        end
        idle(0);
        check("stream_rd_stalls", 64'(tw), 64'd0);
        wait_drain(0);
        // the first entry is the last write's response
        check("stream_count", 64'(log0.size()), 64'd17);
        for (int i = 0; i < 16; i++)
            if (i + 1 < log0.size())
                check("stream_rdata", 64'(log0[i+1]), 64'({32'hA5A5_0000 + 32'(i), 1'b0}));

        // Wait states = 3: each command accepted in the 4th valid cycle
        op_expect(1, "ws_wr", BASE + 32'h40, 1'b0, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0, 3);
        op_expect(1, "ws_rd", BASE + 32'h40, 1'b1, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0, 3);
        for (int i = 0; i < 4; i++) begin
            issue(1, BASE + 32'h80 + 32'(4 * i), 1'b0, 32'h5A00_0000 + 32'(i), 4'hF, w);
            check("ws_stream_wait", 64'(w), 64'd3);
        end
        idle(1);
        op_expect(1, "ws_rd_s2", BASE + 32'h88, 1'b1, 32'd0, 4'h0, 32'h5A00_0002, 1'b0, 3);
        // valid dropped after two cycles: the wait count holds
        set_cmd(1, 1'b1, BASE + 32'h40, 1'b1, 32'd0, 4'h0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 idle(1);
        repeat (2) @(posedge clk);
        #1;
        op_expect(1, "ws_hold", BASE + 32'h40, 1'b1, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0, 1);

        // Reset with two responses pending
        set_rr(0, 1'b0);
        issue(0, BASE + 32'h10, 1'b1, 32'd0, 4'h0, w);
        issue(0, BASE + 32'h20, 1'b1, 32'd0, 4'h0, w);
        idle(0);
        @(negedge clk);
        check("pending_valid", 64'(b0.icb_rsp_valid), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(b0.icb_rsp_valid), 64'd0);
        check("rst_async_ready", 64'(b0.icb_cmd_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(b0.icb_cmd_ready), 64'd1);
        check("post_rst_valid", 64'(b0.icb_rsp_valid), 64'd0);
        @(posedge clk); #1;
        set_rr(0, 1'b1);
        op_expect(0, "post_rst_rd", BASE + 32'h10, 1'b1, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
